// File: rtl/yuepu_player.sv
// Song sequencer: plays a fixed 16-entry note table as one-hot key codes, with a silent gap after each note.
// Latency: start/stop take effect one cycle after sampling, and all outputs are registered; there is no backpressure.
module yuepu_player #(
    parameter int BEAT_DIV   = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [6:0] key,
    output logic [2:0] note_num,
    output logic [3:0] idx,
    output logic       busy,
    output logic       done
);

    localparam int DUR_MAX = 4 * BEAT_DIV - 1;
    localparam int CNT_MAX = (DUR_MAX > GAP_CYCLES - 1) ? DUR_MAX : GAP_CYCLES - 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SOUND, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0]    key_n;
    logic [2:0]    note_n;
    logic [3:0]    idx_n;
    logic          busy_n, done_n;
    logic          ld;
    logic [5:0]    ld_entry;
    logic [5:0]    entry_nxt, entry0;

    // Entry layout {end, beats_m1[1:0], note[2:0]}; entry 14 is a one-beat rest.
    function automatic logic [5:0] song(input logic [3:0] i);
        case (i)
            4'd0:    song = 6'b0_00_001;
            4'd1:    song = 6'b0_00_001;
            4'd2:    song = 6'b0_00_101;
            4'd3:    song = 6'b0_00_101;
            4'd4:    song = 6'b0_00_110;
            4'd5:    song = 6'b0_00_110;
            4'd6:    song = 6'b0_01_101;
            4'd7:    song = 6'b0_00_100;
            4'd8:    song = 6'b0_00_100;
            4'd9:    song = 6'b0_00_011;
            4'd10:   song = 6'b0_00_011;
            4'd11:   song = 6'b0_00_010;
            4'd12:   song = 6'b0_00_010;
            4'd13:   song = 6'b0_01_001;
            4'd14:   song = 6'b0_00_000;
            default: song = 6'b1_00_000;
        endcase
    endfunction

    function automatic logic [6:0] onehot(input logic [2:0] n);
        onehot = (n == 3'd0) ? 7'd0 : (7'd1 << (n - 3'd1));
    endfunction

    function automatic logic [CW-1:0] dur_tc(input logic [1:0] bm1);
        dur_tc = CW'((int'(bm1) + 1) * BEAT_DIV - 1);
    endfunction

    assign entry_nxt = song(idx + 4'd1);
    assign entry0    = song(4'd0);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        key_n    = key;
        note_n   = note_num;
        busy_n   = busy;
        done_n   = 1'b0;
        ld       = 1'b0;
        ld_entry = entry0;

        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = 4'd0;
            key_n   = 7'd0;
            note_n  = 3'd0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ld    = 1'b1;
                        idx_n = 4'd0;
                    end
                end
                SOUND: begin
                    if (cnt == '0) begin
                        state_n = GAP;
                        cnt_n   = CW'(GAP_CYCLES - 1);
                        key_n   = 7'd0;
                        note_n  = 3'd0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else if (!entry_nxt[5]) begin
                        ld       = 1'b1;
                        ld_entry = entry_nxt;
                        idx_n    = idx + 4'd1;
                    end else begin
                        done_n = 1'b1;
                        idx_n  = 4'd0;
                        if (loop_en) begin
                            ld = 1'b1;
                        end else begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            busy_n  = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase

            if (ld) begin
                state_n = SOUND;
                cnt_n   = dur_tc(ld_entry[4:3]);
                key_n   = onehot(ld_entry[2:0]);
                note_n  = ld_entry[2:0];
                busy_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 4'd0;
            key      <= 7'd0;
            note_num <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            key      <= key_n;
            note_num <= note_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule
